// File: rtl/bank_pkg.sv
// Shared definitions for the synthesizer voice bank: command opcodes, wave codes,
// sample geometry and the constant phase-increment ROM builder.
package bank_pkg;

    localparam int SAMPLE_W        = 24;
    localparam int NVOICES_DEFAULT = 10;
    localparam int PHW_DEFAULT     = 32;
    localparam int NOTES           = 128;

    localparam logic [1:0] OP_IDLE   = 2'b00;
    localparam logic [1:0] OP_ON     = 2'b01;
    localparam logic [1:0] OP_OFF    = 2'b10;
    localparam logic [1:0] OP_ALLOFF = 2'b11;

    localparam logic [1:0] WAVE_SAW     = 2'b00;
    localparam logic [1:0] WAVE_SQUARE  = 2'b01;
    localparam logic [1:0] WAVE_TRI     = 2'b10;
    localparam logic [1:0] WAVE_SAW_ALT = 2'b11;

    typedef logic [NOTES-1:0][31:0] inc_rom_t;

    // Evaluated only at elaboration time; the result is a fixed 128-entry table.
    function automatic inc_rom_t build_inc_rom(input int fs, input int phw);
        inc_rom_t rom;
        real      inc_real;
        for (int n = 0; n < NOTES; n++) begin
            inc_real = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0))
                     * (2.0 ** real'(phw)) / real'(fs);
            rom[n]   = 32'($rtoi(inc_real + 0.5));
        end
        return rom;
    endfunction

endpackage

// File: rtl/bank_voice.sv
// One oscillator voice: slot state (active, note, wave, phase) and the waveform
// shaper that turns the phase into a signed 24-bit sample.
module bank_voice
    import bank_pkg::*;
#(
    parameter int PHW = PHW_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trig,
    input  logic [6:0]          trig_note,
    input  logic [1:0]          trig_wave,
    input  logic                kill,
    input  logic                advance,
    input  logic [PHW-1:0]      inc,
    output logic                active,
    output logic [6:0]          note,
    output logic [SAMPLE_W-1:0] sample
);

    logic           active_q, active_d;
    logic [6:0]     note_q, note_d;
    logic [1:0]     wave_q, wave_d;
    logic [PHW-1:0] phase_q, phase_d;

    logic [SAMPLE_W-1:0] shaped;
    logic [SAMPLE_W-2:0] tri_t;

    // A trigger in the same cycle as this slot's advance wins: the voice restarts at phase 0.
    always_comb begin
        active_d = active_q;
        note_d   = note_q;
        wave_d   = wave_q;
        phase_d  = phase_q;
        if (advance && active_q) begin
            phase_d = phase_q + inc;
        end
        if (trig) begin
            active_d = 1'b1;
            note_d   = trig_note;
            wave_d   = trig_wave;
            phase_d  = '0;
        end else if (kill) begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            note_q   <= '0;
            wave_q   <= WAVE_SAW;
            phase_q  <= '0;
        end else begin
            active_q <= active_d;
            note_q   <= note_d;
            wave_q   <= wave_d;
            phase_q  <= phase_d;
        end
    end

    always_comb begin
        tri_t = phase_q[PHW-1] ? ~phase_q[PHW-2 -: SAMPLE_W-1] : phase_q[PHW-2 -: SAMPLE_W-1];
        case (wave_q)
            WAVE_SQUARE: shaped = phase_q[PHW-1] ? 24'h800001 : 24'h7FFFFF;
            WAVE_TRI:    shaped = {tri_t, 1'b0} ^ 24'h800000;
            default:     shaped = phase_q[PHW-1 -: SAMPLE_W] ^ 24'h800000;
        endcase
    end

    assign active = active_q;
    assign note   = note_q;
    assign sample = active_q ? shaped : '0;

endmodule

// File: rtl/bank_manager.sv
// Voice bank top: decodes note commands, allocates voices, walks the slots
// round-robin and registers one voice sample per enabled cycle for the mixer.
module bank_manager
    import bank_pkg::*;
#(
    parameter int NVOICES = NVOICES_DEFAULT,
    parameter int FS      = 96000,
    parameter int PHW     = PHW_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic [15:0]         i_data,
    output logic [SAMPLE_W-1:0] o_signal
);

    localparam int       SLOT_W  = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam inc_rom_t INC_ROM = build_inc_rom(FS, PHW);

    logic [1:0] cmd_op;
    logic [1:0] cmd_wave;
    logic [6:0] cmd_note;
    logic       unused_cmd_bits;

    logic [NVOICES-1:0]  voice_active;
    logic [6:0]          voice_note   [NVOICES];
    logic [SAMPLE_W-1:0] voice_sample [NVOICES];

    logic [NVOICES-1:0] match;
    logic [NVOICES-1:0] free_oh;
    logic [NVOICES-1:0] trig;
    logic [NVOICES-1:0] kill;
    logic [NVOICES-1:0] advance;
    logic [PHW-1:0]     slot_inc;

    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SAMPLE_W-1:0] o_signal_q, o_signal_d;

    assign cmd_op          = i_data[15:14];
    assign cmd_wave        = i_data[13:12];
    assign cmd_note        = i_data[6:0];
    assign unused_cmd_bits = ^i_data[11:7];

    // Lowest-index inactive voice; all zeros when the bank is full, which drops the note-on.
    always_comb begin
        logic taken;
        taken   = 1'b0;
        free_oh = '0;
        for (int i = 0; i < NVOICES; i++) begin
            match[i] = voice_active[i] && (voice_note[i] == cmd_note);
            if (!voice_active[i] && !taken) begin
                free_oh[i] = 1'b1;
                taken      = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NVOICES; i++) begin
            trig[i]    = (cmd_op == OP_ON) && ((|match) ? match[i] : free_oh[i]);
            kill[i]    = ((cmd_op == OP_OFF) && match[i]) || (cmd_op == OP_ALLOFF);
            advance[i] = clk_en && (slot_q == SLOT_W'(i));
        end
    end

    assign slot_inc = PHW'(INC_ROM[voice_note[slot_q]]);

    for (genvar g = 0; g < NVOICES; g++) begin : g_voice
        bank_voice #(
            .PHW(PHW)
        ) u_voice (
            .clk       (clk),
            .reset     (reset),
            .trig      (trig[g]),
            .trig_note (cmd_note),
            .trig_wave (cmd_wave),
            .kill      (kill[g]),
            .advance   (advance[g]),
            .inc       (slot_inc),
            .active    (voice_active[g]),
            .note      (voice_note[g]),
            .sample    (voice_sample[g])
        );
    end

    always_comb begin
        slot_d     = slot_q;
        o_signal_d = o_signal_q;
        if (clk_en) begin
            o_signal_d = voice_sample[slot_q];
            slot_d     = (slot_q == SLOT_W'(NVOICES - 1)) ? '0 : slot_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q     <= '0;
            o_signal_q <= '0;
        end else begin
            slot_q     <= slot_d;
            o_signal_q <= o_signal_d;
        end
    end

    assign o_signal = o_signal_q;

endmodule

// File: tb/tb_bank_manager.sv
// Self-checking bench for bank_manager: a voice-list model of the bank predicts
// every registered sample; directed scenarios pin key values, then random traffic.
`timescale 1ns/1ps
module tb_bank_manager;

    localparam int NV = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [15:0] i_data;
    logic [23:0] o_signal;

    int checks   = 0;
    int failures = 0;

    int       inc_tab [128];
    bit       m_act   [NV];
    bit [6:0] m_note  [NV];
    bit [1:0] m_wave  [NV];
    bit [31:0] m_phase [NV];
    int       m_slot;
    int       exp_out;
    int       out_slot;
    bit       out_fresh;
    bit       m_found;
    bit       cmp_en = 1'b0;

    bank_manager #(
        .NVOICES (NV),
        .FS      (96000),
        .PHW     (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .i_data   (i_data),
        .o_signal (o_signal)
    );

    always #5 clk = ~clk;

    function automatic int wave_value(input bit [1:0] w, input bit [31:0] ph);
        int top24;
        top24 = int'(ph >> 8);
        case (w)
            2'b01: return (ph >= 32'h8000_0000) ? -8388607 : 8388607;
            2'b10: begin
                if (ph < 32'h8000_0000) return 2 * top24 - 8388608;
                return 2 * (8388607 - int'((ph - 32'h8000_0000) >> 8)) - 8388608;
            end
            default: return top24 - 8388608;
        endcase
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Voice-list model: emit the current slot's sample from pre-edge state, then apply the command.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NV; i++) begin
                m_act[i]   = 1'b0;
                m_note[i]  = '0;
                m_wave[i]  = '0;
                m_phase[i] = '0;
            end
            m_slot    = 0;
            exp_out   = 0;
            out_slot  = 0;
            out_fresh = 1'b0;
        end else begin
            out_fresh = 1'b0;
            if (clk_en) begin
                exp_out   = m_act[m_slot] ? wave_value(m_wave[m_slot], m_phase[m_slot]) : 0;
                out_slot  = m_slot;
                out_fresh = 1'b1;
                if (m_act[m_slot]) m_phase[m_slot] += inc_tab[m_note[m_slot]];
                m_slot = (m_slot + 1) % NV;
            end
            case (i_data[15:14])
                2'b01: begin
                    m_found = 1'b0;
                    for (int i = 0; i < NV; i++) begin
                        if (m_act[i] && m_note[i] == i_data[6:0]) begin
                            m_phase[i] = '0;
                            m_wave[i]  = i_data[13:12];
                            m_found    = 1'b1;
                        end
                    end
                    for (int i = 0; i < NV; i++) begin
                        if (!m_found && !m_act[i]) begin
                            m_act[i]   = 1'b1;
                            m_note[i]  = i_data[6:0];
                            m_wave[i]  = i_data[13:12];
                            m_phase[i] = '0;
                            m_found    = 1'b1;
                        end
                    end
                end
                2'b10: begin
                    for (int i = 0; i < NV; i++)
                        if (m_act[i] && m_note[i] == i_data[6:0]) m_act[i] = 1'b0;
                end
                2'b11: begin
                    for (int i = 0; i < NV; i++) m_act[i] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) check_output("o_signal", int'($signed(o_signal)), exp_out);
    end

    task automatic apply_stimulus(input logic [15:0] cmd, input logic en);
        i_data = cmd;
        clk_en = en;
        @(posedge clk);
        #1;
        i_data = 16'h0000;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(input int s, input string name, input int expected);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3 * NV && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_fresh && out_slot == s) seen = 1'b1;
        end
        if (seen) check_output(name, int'($signed(o_signal)), expected);
        else      check_output({name, "_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int active_cnt;
        int r;
        int dropped_active;

        reset  = 1'b1;
        clk_en = 1'b0;
        i_data = 16'h0000;
        for (int n = 0; n < 128; n++)
            inc_tab[n] = $rtoi(440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0))
                               * 4294967296.0 / 96000.0 + 0.5);

        check_output("model_inc69", inc_tab[69], 19685267);
        check_output("model_saw_step", wave_value(2'b00, 32'd19685267), -8311713);
        check_output("model_tri_peak", wave_value(2'b10, 32'h8000_0000), 8388606);

        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        reset  = 1'b0;
        clk_en = 1'b1;

        $display("[TB] idle after reset");
        for (int k = 0; k < 3 * NV; k++) begin
            @(negedge clk);
            check_output("idle_zero", int'($signed(o_signal)), 0);
        end
        @(posedge clk);
        #1;

        $display("[TB] single saw note 69");
        apply_stimulus(16'h4045, 1'b1);
        wait_slot(0, "saw_first", -8388608);
        wait_slot(0, "saw_second", -8311713);

        $display("[TB] note-off and voice reuse");
        apply_stimulus(16'hC000, 1'b1);
        apply_stimulus(16'h403C, 1'b1);
        apply_stimulus(16'h4040, 1'b1);
        apply_stimulus(16'h803C, 1'b1);
        wait_slot(0, "off_slot0", 0);
        apply_stimulus(16'h4043, 1'b1);
        wait_slot(0, "reuse_voice0", -8388608);
        check_output("model_reuse_note", int'(m_note[0]), 67);

        $display("[TB] bank full");
        apply_stimulus(16'hC000, 1'b1);
        for (int k = 0; k <= NV; k++) apply_stimulus(16'h4000 | 16'(40 + k), 1'b1);
        active_cnt     = 0;
        dropped_active = 0;
        for (int i = 0; i < NV; i++) begin
            if (m_act[i]) active_cnt++;
            if (m_act[i] && m_note[i] == 7'd50) dropped_active = 1;
        end
        check_output("model_full_count", active_cnt, NV);
        check_output("model_dropped", dropped_active, 0);
        run_cycles(2 * NV);
        apply_stimulus(16'hC000, 1'b1);
        for (int k = 0; k < 2 * NV; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_output("alloff_zero", int'($signed(o_signal)), 0);
        end
        @(posedge clk);
        #1;

        $display("[TB] note-on while frozen");
        apply_stimulus(16'h4045, 1'b0);
        run_cycles(19);
        clk_en = 1'b1;
        wait_slot(0, "resume_slot0", -8388608);

        $display("[TB] square and triangle");
        apply_stimulus(16'hC000, 1'b1);
        apply_stimulus(16'h5045, 1'b1);
        wait_slot(0, "square_first", 8388607);
        run_cycles(2400);
        apply_stimulus(16'hC000, 1'b1);
        apply_stimulus(16'h6045, 1'b1);
        wait_slot(0, "tri_first", -8388608);
        run_cycles(1200);
        reset = 1'b1;
        @(negedge clk);
        check_output("reset_zero", int'($signed(o_signal)), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] random traffic");
        for (int k = 0; k < 4000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 8)
                i_data = {2'b01, 2'($urandom_range(0, 3)), 5'd0, 7'($urandom_range(60, 66))};
            else if (r < 12)
                i_data = {2'b10, 2'b00, 5'd0, 7'($urandom_range(60, 66))};
            else if (r == 12)
                i_data = 16'hC000;
            else
                i_data = 16'h0000;
            clk_en = ($urandom_range(0, 9) != 0);
            @(posedge clk);
            #1;
        end
        i_data = 16'h0000;
        clk_en = 1'b1;
        run_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
